// File: rtl/fft_frame_loader_if.sv
// Sample-stream and FFT-side signal bundle for fft_frame_loader.
// The slave modport is the loader's view; master is the producer/FFT-side view.
interface fft_frame_loader_if #(
    parameter int unsigned N  = 16,
    parameter int unsigned DW = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_re;
    logic [DW-1:0]     in_im;
    logic              in_last;
    logic [2*N*DW-1:0] fft_data;
    logic              fft_start;
    logic              fft_endop;
    logic              err_frame;

    modport master (
        output in_valid, in_re, in_im, in_last, fft_endop,
        input  in_ready, fft_data, fft_start, err_frame
    );

    modport slave (
        input  in_valid, in_re, in_im, in_last, fft_endop,
        output in_ready, fft_data, fft_start, err_frame
    );
endinterface

// File: rtl/fft_frame_loader.sv
// Packs N complex samples from a valid/ready stream into ping-pong frame banks and
// hands each full bank to the FFT core with a one-cycle start, holding it until endop.
module fft_frame_loader #(
    parameter int unsigned N  = 16,
    parameter int unsigned DW = 16
) (
    input  logic clock,
    input  logic reset,
    fft_frame_loader_if.slave bus
);
    localparam int unsigned FW = 2 * N * DW;
    localparam int unsigned SW = 2 * DW;
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {BkEmpty, BkFilling, BkFull, BkIssued} bank_st_e;
    typedef enum logic [1:0] {StIdle, StStart, StWait} fsm_e;

    bank_st_e          bank_st_q [2];
    bank_st_e          bank_st_d [2];
    logic [FW-1:0]     bank_q [2];
    logic [FW-1:0]     bank_d [2];
    logic              wr_bank_q, wr_bank_d;
    logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
    logic              rd_bank_q, rd_bank_d;
    logic              order_q, order_d;
    fsm_e              fsm_q, fsm_d;
    logic [FW-1:0]     data_q, data_d;
    logic              err_q, err_d;
    logic              in_ready;
    logic              accept;
    logic              last_beat;

    always_comb begin
        bank_st_d = bank_st_q;
        bank_d    = bank_q;
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_bank_d = rd_bank_q;
        order_d   = order_q;
        fsm_d     = fsm_q;
        data_d    = data_q;
        err_d     = 1'b0;

        in_ready  = !reset && (bank_st_q[wr_bank_q] == BkEmpty ||
                               bank_st_q[wr_bank_q] == BkFilling);
        accept    = bus.in_valid && in_ready;
        last_beat = (wr_cnt_q == CW'(N - 1));

        // Banks fill strictly alternately, so order_q is simply the next bank to issue.
        case (fsm_q)
            StIdle: begin
                if (bank_st_q[order_q] == BkFull) begin
                    fsm_d     = StStart;
                    rd_bank_d = order_q;
                    order_d   = !order_q;
                    data_d    = bank_q[order_q];
                end
            end
            StStart: begin
                bank_st_d[rd_bank_q] = BkIssued;
                fsm_d                = StWait;
            end
            StWait: begin
                if (bus.fft_endop) begin
                    bank_st_d[rd_bank_q] = BkEmpty;
                    fsm_d                = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase

        // The write bank is never the bank the FSM is touching, so these updates don't clash.
        if (accept) begin
            if (bus.in_last && !last_beat) begin
                bank_st_d[wr_bank_q] = BkEmpty;
                wr_cnt_d             = '0;
                err_d                = 1'b1;
            end else begin
                bank_d[wr_bank_q][int'(wr_cnt_q) * int'(SW) +: SW] = {bus.in_re, bus.in_im};
                if (last_beat) begin
                    bank_st_d[wr_bank_q] = BkFull;
                    wr_bank_d            = !wr_bank_q;
                    wr_cnt_d             = '0;
                    err_d                = !bus.in_last;
                end else begin
                    bank_st_d[wr_bank_q] = BkFilling;
                    wr_cnt_d             = wr_cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bank_st_q[0] <= BkEmpty;
            bank_st_q[1] <= BkEmpty;
            wr_bank_q    <= 1'b0;
            wr_cnt_q     <= '0;
            rd_bank_q    <= 1'b0;
            order_q      <= 1'b0;
            fsm_q        <= StIdle;
            data_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            bank_st_q <= bank_st_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_bank_q <= rd_bank_d;
            order_q   <= order_d;
            fsm_q     <= fsm_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    // Sample storage needs no reset; bank state alone decides what is valid.
    always_ff @(posedge clock) begin
        bank_q <= bank_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.fft_data  = data_q;
    assign bus.fft_start = (fsm_q == StStart);
    assign bus.err_frame = err_q;
endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench for fft_frame_loader: scoreboard of expected frames plus a
// table of framing scenarios and hand-written multi-cycle corner cases.
module tb_fft_frame_loader;
    localparam int unsigned N  = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned FW = 2 * N * DW;

    typedef struct {
        int len;
        int last_pos;
        int exp_err;
        int exp_start;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fft_frame_loader_if #(.N(N), .DW(DW)) bus ();

    fft_frame_loader #(.N(N), .DW(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int            n_vec = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            n_start = 0;
    int            n_err = 0;
    int            last_start_cyc = 0;
    int            acc_cyc = 0;
    logic [FW-1:0] start_data = '0;
    logic [FW-1:0] last_exp = '0;
    logic [FW-1:0] sb_q [$];
    bit            f2_done = 0;
    bit            f3_done = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every fft_start pops the oldest expected frame.
    always @(negedge clock) begin
        if (bus.err_frame) n_err++;
        if (bus.fft_start) begin
            n_start++;
            last_start_cyc = cyc;
            start_data     = bus.fft_data;
            if (sb_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_start: got start at cycle %0d expected none", cyc);
            end else begin
                last_exp = sb_q.pop_front();
                check("frame_data", bus.fft_data, last_exp);
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
        int t;
        bit ok;
        bus.in_valid = 1'b1;
        bus.in_re    = re;
        bus.in_im    = im;
        bus.in_last  = last;
        t  = 0;
        ok = 0;
        while (!ok) begin
            @(negedge clock);
            if (bus.in_ready) begin
                ok = 1;
            end else begin
                t++;
                if (t > 300) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL beat_timeout: got in_ready=0 for %0d cycles expected 1", t);
                    break;
                end
                @(posedge clock);
                #1;
            end
        end
        acc_cyc = cyc;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input int len, input int last_pos, input bit ramp);
        logic [FW-1:0] exp;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        exp = '0;
        for (int k = 0; k < len; k++) begin
            if (ramp) begin
                re = DW'(k);
                im = DW'(-k);
            end else begin
                re = DW'($urandom);
                im = DW'($urandom);
            end
            exp[k*2*DW +: 2*DW] = {re, im};
            send_beat(re, im, k == last_pos);
        end
        if (len == N) sb_q.push_back(exp);
    endtask

    task automatic wait_start(input int target, input string name);
        int t;
        t = 0;
        while (n_start < target && t < 60) begin
            @(posedge clock);
            t++;
        end
        check(name, n_start, target);
    endtask

    task automatic pulse_endop();
        bus.fft_endop = 1'b1;
        @(posedge clock);
        #1;
        bus.fft_endop = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [8];
        int   s0;
        int   e0;
        int   t;
        int   endop_cyc;

        tbl[0] = '{16, 15, 0, 1};
        tbl[1] = '{8, 7, 1, 0};
        tbl[2] = '{16, 15, 0, 1};
        tbl[3] = '{16, -1, 1, 1};
        tbl[4] = '{1, 0, 1, 0};
        tbl[5] = '{16, 15, 0, 1};
        tbl[6] = '{15, 14, 1, 0};
        tbl[7] = '{16, 15, 0, 1};

        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.in_last   = 1'b0;
        bus.fft_endop = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_fft_start", bus.fft_start, 0);
        check("rst_err_frame", bus.err_frame, 0);
        check("rst_fft_data", bus.fft_data, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_rst", bus.in_ready, 1);
        @(posedge clock);
        #1;

        // Ramp frame: latency and packing
        send_frame(N, N - 1, 1'b1);
        wait_start(1, "t1_start_count");
        check("t1_latency", last_start_cyc, acc_cyc + 2);
        check("t1_low_word", start_data[31:0], 32'h0000_0000);
        check("t1_high_word", start_data[511:480], 32'h000F_FFF1);
        repeat (5) @(posedge clock);
        check("t1_single_start", n_start, 1);

        // Back-to-back frames with endop held low: both banks occupied
        #1;
        fork
            begin
                send_frame(N, N - 1, 1'b0);
                f2_done = 1;
                send_frame(N, N - 1, 1'b0);
                f3_done = 1;
            end
        join_none
        t = 0;
        while (!f2_done && t < 200) begin
            @(posedge clock);
            t++;
        end
        check("t2_frame2_filled", f2_done, 1);
        @(negedge clock);
        check("t2_ready_low", bus.in_ready, 0);
        repeat (5) @(posedge clock);
        check("t2_no_second_start", n_start, 1);
        check("t2_frame3_blocked", f3_done, 0);
        #1;
        bus.fft_endop = 1'b1;
        endop_cyc = cyc;
        @(negedge clock);
        check("t2_ready_during_endop", bus.in_ready, 0);
        @(posedge clock);
        #1;
        bus.fft_endop = 1'b0;
        @(negedge clock);
        check("t2_ready_after_endop", bus.in_ready, 1);
        wait_start(2, "t2_frame2_start");
        check("t2_endop_latency", last_start_cyc, endop_cyc + 2);
        t = 0;
        while (!f3_done && t < 200) begin
            @(posedge clock);
            t++;
        end
        check("t2_frame3_filled", f3_done, 1);
        #1;
        pulse_endop();
        wait_start(3, "t2_frame3_start");
        repeat (2) @(posedge clock);
        #1;
        pulse_endop();
        repeat (3) @(posedge clock);
        #1;

        // Framing scenarios
        for (int i = 0; i < 8; i++) begin
            s0 = n_start;
            e0 = n_err;
            send_frame(tbl[i].len, tbl[i].last_pos, 1'b0);
            repeat (6) @(posedge clock);
            check($sformatf("tbl%0d_starts", i), n_start - s0, tbl[i].exp_start);
            check($sformatf("tbl%0d_errs", i), n_err - e0, tbl[i].exp_err);
            #1;
            if (tbl[i].exp_start != 0) pulse_endop();
            repeat (2) @(posedge clock);
            #1;
        end

        // endop in IDLE and in the START cycle is ignored
        pulse_endop();
        repeat (3) @(negedge clock);
        check("t5_idle_hold", bus.fft_data, last_exp);
        @(posedge clock);
        #1;
        s0 = n_start;
        send_frame(N, N - 1, 1'b0);
        @(posedge clock);
        #1;
        bus.fft_endop = 1'b1;
        @(negedge clock);
        check("t5_endop_in_start", bus.fft_start, 1);
        @(posedge clock);
        #1;
        bus.fft_endop = 1'b0;
        repeat (6) @(posedge clock);
        check("t5_one_start", n_start - s0, 1);
        @(negedge clock);
        check("t5_wait_hold", bus.fft_data, last_exp);
        @(posedge clock);
        #1;
        send_frame(N, N - 1, 1'b0);
        repeat (6) @(posedge clock);
        check("t5_still_waiting", n_start - s0, 1);
        @(negedge clock);
        check("t5_wait_hold2", bus.fft_data, last_exp);
        @(posedge clock);
        #1;
        pulse_endop();
        wait_start(s0 + 2, "t5_next_start");
        repeat (2) @(posedge clock);
        #1;

        // Reset with a frame in WAIT and a partial frame in the other bank
        send_frame(10, -1, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("t6_ready_in_reset", bus.in_ready, 0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("t6_data_cleared", bus.fft_data, 0);
        check("t6_start_low", bus.fft_start, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        s0 = n_start;
        repeat (10) @(posedge clock);
        check("t6_no_start", n_start - s0, 0);
        #1;
        send_frame(N, N - 1, 1'b0);
        wait_start(s0 + 1, "t6_fresh_start");
        repeat (5) @(posedge clock);
        check("t6_single_start", n_start - s0, 1);
        check("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
